// File: rtl/bios_fetch_unit.sv
// BIOS instruction-fetch front end: owns the fetch PC, drives BIOS port A, pairs words with PCs.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module bios_fetch_unit #(
  parameter int          AWIDTH    = 12,
  parameter logic [31:0] BIOS_BASE = 32'h4000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [AWIDTH-1:0] bios_addr,
  input  logic [31:0]       bios_dout,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              inst_valid,
  output logic              fault,
  output logic [31:0]       fault_pc,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_next;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        valid;

  function automatic logic pc_legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc[31:AWIDTH+2] == BIOS_BASE[31:AWIDTH+2]);
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_next    = pc_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    valid      = 1'b0;
    case (state_q)
      BOOT, RUN: begin
        if (redirect)             pc_next = redirect_pc;
        else if (state_q == BOOT) pc_next = BIOS_BASE;
        else if (stall)           pc_next = pc_q;
        else                      pc_next = pc_q + 32'd4;
        // The word on a redirect cycle is wrong-path and is squashed.
        valid = (state_q == RUN) && !redirect;
        if (pc_legal(pc_next)) begin
          state_d = RUN;
          pc_d    = pc_next;
        end else begin
          state_d    = HALT;
          fault_pc_d = pc_next;
        end
      end
      HALT: begin
        if (redirect) begin
          if (pc_legal(redirect_pc)) begin
            pc_next = redirect_pc;
            pc_d    = redirect_pc;
            state_d = RUN;
          end else begin
            fault_pc_d = redirect_pc;
          end
        end
      end
      default: state_d = BOOT;
    endcase
    if (rst) pc_next = BIOS_BASE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= BIOS_BASE;
      fault_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign bios_addr  = pc_next[AWIDTH+1:2];
  assign inst       = bios_dout;
  assign inst_pc    = pc_q;
  assign inst_valid = valid;
  assign fault      = (state_q == HALT);
  assign fault_pc   = fault_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (valid && !stall)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if ((state_q == RUN) && stall && !redirect)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign fetch_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_bios_fetch_unit.sv
// Testbench for bios_fetch_unit: per-cycle vector table with a scoreboard queue, plus reset sequence.
module tb_bios_fetch_unit;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [11:0] bios_addr;
  logic [31:0] bios_dout;
  logic [31:0] inst, inst_pc, fault_pc, fetch_count, stall_count;
  logic        inst_valid, fault;

  int checks = 0;
  int failures = 0;

  bios_fetch_unit #(.AWIDTH(12), .BIOS_BASE(B)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .bios_addr(bios_addr), .bios_dout(bios_dout), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .fault(fault), .fault_pc(fault_pc),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] idx);
    return {idx[15:0] ^ 16'hA5C3, ~idx[15:0]};
  endfunction

  // Synchronous-read BIOS model
  always @(posedge clk) bios_dout <= word_of({20'd0, bios_addr});

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [11:0] exp_addr;
    logic        exp_fault;
    logic [31:0] exp_fpc;
  } vec_t;

  vec_t vecs[22];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic v, input logic [31:0] pc, input logic [11:0] a,
                              input logic f, input logic [31:0] fpc);
    vec_t t;
    t.stall = s; t.redirect = r; t.rpc = rpc; t.exp_valid = v; t.exp_pc = pc;
    t.exp_addr = a; t.exp_fault = f; t.exp_fpc = fpc;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic chk_reset_values(input int tag);
    chk("rst_valid", tag, {31'd0, inst_valid}, 32'd0);
    chk("rst_fault", tag, {31'd0, fault}, 32'd0);
    chk("rst_fault_pc", tag, fault_pc, 32'd0);
    chk("rst_inst_pc", tag, inst_pc, B);
    chk("rst_addr", tag, {20'd0, bios_addr}, 32'd0);
    chk("rst_fetch_cnt", tag, fetch_count, 32'd0);
    chk("rst_stall_cnt", tag, stall_count, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t e;
    logic [31:0] m_fetch, m_stall, exp_fc, exp_sc;
    m_fetch = 0;
    m_stall = 0;

    //              s  r  rpc            v  pc          addr    f  fault_pc
    vecs[0]  = mk(0, 0, 32'd0,          0, B,          12'h000, 0, 32'd0);
    vecs[1]  = mk(0, 0, 32'd0,          1, B,          12'h001, 0, 32'd0);
    vecs[2]  = mk(0, 0, 32'd0,          1, B+32'h4,    12'h002, 0, 32'd0);
    vecs[3]  = mk(0, 0, 32'd0,          1, B+32'h8,    12'h003, 0, 32'd0);
    vecs[4]  = mk(0, 0, 32'd0,          1, B+32'hC,    12'h004, 0, 32'd0);
    vecs[5]  = mk(1, 0, 32'd0,          1, B+32'h10,   12'h004, 0, 32'd0);
    vecs[6]  = mk(1, 0, 32'd0,          1, B+32'h10,   12'h004, 0, 32'd0);
    vecs[7]  = mk(1, 0, 32'd0,          1, B+32'h10,   12'h004, 0, 32'd0);
    vecs[8]  = mk(1, 1, B+32'h100,      0, B+32'h10,   12'h040, 0, 32'd0);
    vecs[9]  = mk(0, 0, 32'd0,          1, B+32'h100,  12'h041, 0, 32'd0);
    vecs[10] = mk(0, 1, B+32'h102,      0, B+32'h104,  12'h040, 0, 32'd0);
    vecs[11] = mk(1, 0, 32'd0,          0, B+32'h104,  12'h041, 1, B+32'h102);
    vecs[12] = mk(0, 1, B,              0, B+32'h104,  12'h000, 1, B+32'h102);
    vecs[13] = mk(0, 0, 32'd0,          1, B,          12'h001, 0, B+32'h102);
    vecs[14] = mk(0, 1, B+32'h3FF8,     0, B+32'h4,    12'hFFE, 0, B+32'h102);
    vecs[15] = mk(0, 0, 32'd0,          1, B+32'h3FF8, 12'hFFF, 0, B+32'h102);
    vecs[16] = mk(0, 0, 32'd0,          1, B+32'h3FFC, 12'h000, 0, B+32'h102);
    vecs[17] = mk(0, 0, 32'd0,          0, B+32'h3FFC, 12'hFFF, 1, B+32'h4000);
    vecs[18] = mk(0, 1, 32'h1000_0000,  0, B+32'h3FFC, 12'hFFF, 1, B+32'h4000);
    vecs[19] = mk(0, 0, 32'd0,          0, B+32'h3FFC, 12'hFFF, 1, 32'h1000_0000);
    vecs[20] = mk(0, 1, B+32'h40,       0, B+32'h3FFC, 12'h010, 1, 32'h1000_0000);
    vecs[21] = mk(0, 0, 32'd0,          1, B+32'h40,   12'h011, 0, 32'h1000_0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_values(0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      stall = vecs[i].stall;
      redirect = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      exp_q.push_back(vecs[i]);
      if (vecs[i].exp_valid && !vecs[i].stall) m_fetch++;
      if (vecs[i].stall && !vecs[i].redirect && !vecs[i].exp_fault && i != 0) m_stall++;
      @(negedge clk);
      e = exp_q.pop_front();
      chk("inst_valid", i, {31'd0, inst_valid}, {31'd0, e.exp_valid});
      chk("inst_pc", i, inst_pc, e.exp_pc);
      chk("bios_addr", i, {20'd0, bios_addr}, {20'd0, e.exp_addr});
      chk("fault", i, {31'd0, fault}, {31'd0, e.exp_fault});
      chk("fault_pc", i, fault_pc, e.exp_fpc);
      if (e.exp_valid) chk("inst", i, inst, word_of((e.exp_pc - B) >> 2));
      @(posedge clk); #1;
    end

    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
`ifdef FETCH_PERF_CNT_EN
    exp_fc = m_fetch;
    exp_sc = m_stall;
`else
    exp_fc = 32'd0;
    exp_sc = 32'd0;
`endif
    @(negedge clk);
    chk("pre_rst_pc", 0, inst_pc, B+32'h44);
    chk("fetch_count", 0, fetch_count, exp_fc);
    chk("stall_count", 0, stall_count, exp_sc);

    // Asynchronous reset mid-run, checked before any clock edge
    #1 rst = 1'b1;
    #1 chk_reset_values(1);
    @(posedge clk); #1;
    rst = 1'b0;

    @(negedge clk);
    chk("boot_valid", 1, {31'd0, inst_valid}, 32'd0);
    chk("boot_addr", 1, {20'd0, bios_addr}, 32'd0);
    chk("boot_fetch_cnt", 1, fetch_count, 32'd0);
    chk("boot_stall_cnt", 1, stall_count, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reboot_valid", k, {31'd0, inst_valid}, 32'd1);
      chk("reboot_pc", k, inst_pc, B + 32'(4 * k));
      chk("reboot_inst", k, inst, word_of(32'(k)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
